// File: rtl/ram_spi_pkg.sv
// Shared command codes and FSM state encoding for the SPI-to-RAM bridge.
package ram_spi_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CMD      = 4'd1,
    WR_ADDR  = 4'd2,
    WR_DATA  = 4'd3,
    RD_ADDR  = 4'd4,
    RD_REQ   = 4'd5,
    RD_WAIT  = 4'd6,
    RD_SHIFT = 4'd7,
    DONE     = 4'd8
  } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Serial-in/parallel-out shift register with parallel load; clear has priority.
module spi_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= '0;
    else if (load_en)
      q <= load_data;
    else if (shift_en)
      q <= {q[WIDTH-2:0], ser_in};
  end

endmodule

// File: rtl/ram_spi_bridge.sv
// SPI slave (SCK = clk) translating 2-bit command frames into RAM address,
// write and read operations; read data is returned MSB first on MISO.
module ram_spi_bridge
  import ram_spi_pkg::*;
#(
  parameter int MEM_WIDTH = 16,
  parameter int ADD_SIZE  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [MEM_WIDTH-1:0] ram_din,
  output logic [ADD_SIZE-1:0]  ram_addr_wr,
  output logic [ADD_SIZE-1:0]  ram_addr_rd,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_blk_select,
  input  logic [MEM_WIDTH-1:0] ram_dout
);

  localparam int SR_W  = (MEM_WIDTH > ADD_SIZE) ? MEM_WIDTH : ADD_SIZE;
  localparam int CNT_W = $clog2(SR_W + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADD_SIZE - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(MEM_WIDTH - 1);
  localparam logic [CNT_W-1:0] RD_BITS   = CNT_W'(MEM_WIDTH);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              cmd_hi;
  logic              armed;
  logic              sr_shift;
  logic              sr_load;
  logic [SR_W-1:0]   sr_q;
  logic [SR_W-1:0]   sr_load_data;
  logic [ADD_SIZE-1:0]  addr_next;
  logic [MEM_WIDTH-1:0] data_next;

  // The last payload bit is still on MOSI, so the word is completed combinationally.
  assign addr_next    = {sr_q[ADD_SIZE-2:0], MOSI};
  assign data_next    = {sr_q[MEM_WIDTH-2:0], MOSI};
  assign sr_load_data = SR_W'({ram_dout[MEM_WIDTH-2:0], 1'b0});

  always_comb begin
    sr_shift = 1'b0;
    sr_load  = 1'b0;
    if (!SS_n) begin
      case (state)
        WR_ADDR, WR_DATA, RD_ADDR, RD_SHIFT: sr_shift = 1'b1;
        RD_WAIT:                             sr_load  = 1'b1;
        default: ;
      endcase
    end
  end

  spi_shift_reg #(
    .WIDTH (SR_W)
  ) u_shift (
    .clk       (clk),
    .clr       (SS_n),
    .load_en   (sr_load),
    .load_data (sr_load_data),
    .shift_en  (sr_shift),
    .ser_in    (MOSI),
    .q         (sr_q)
  );

  // armed tracks a high level on SS_n, so a frame cut by reset cannot resume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      cmd_hi         <= 1'b0;
      armed          <= SS_n;
      MISO           <= 1'b0;
      ram_din        <= '0;
      ram_addr_wr    <= '0;
      ram_addr_rd    <= '0;
      ram_wr_en      <= 1'b0;
      ram_rd_en      <= 1'b0;
      ram_blk_select <= 1'b0;
    end else begin
      ram_wr_en      <= 1'b0;
      ram_rd_en      <= 1'b0;
      ram_blk_select <= 1'b0;
      MISO           <= 1'b0;
      if (SS_n) begin
        state <= IDLE;
        cnt   <= '0;
        armed <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (armed) begin
              state  <= CMD;
              cmd_hi <= MOSI;
              armed  <= 1'b0;
            end
          end
          CMD: begin
            cnt <= '0;
            case (cmd_e'({cmd_hi, MOSI}))
              CMD_WR_ADDR: state <= WR_ADDR;
              CMD_WR_DATA: state <= WR_DATA;
              CMD_RD_ADDR: state <= RD_ADDR;
              CMD_RD_DATA: begin
                state          <= RD_REQ;
                ram_rd_en      <= 1'b1;
                ram_blk_select <= 1'b1;
              end
              default: state <= DONE;
            endcase
          end
          WR_ADDR: begin
            if (cnt == ADDR_LAST) begin
              ram_addr_wr <= addr_next;
              state       <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RD_ADDR: begin
            if (cnt == ADDR_LAST) begin
              ram_addr_rd <= addr_next;
              state       <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WR_DATA: begin
            if (cnt == DATA_LAST) begin
              ram_din        <= data_next;
              ram_wr_en      <= 1'b1;
              ram_blk_select <= 1'b1;
              state          <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RD_REQ:  state <= RD_WAIT;
          RD_WAIT: begin
            MISO  <= ram_dout[MEM_WIDTH-1];
            cnt   <= CNT_W'(1);
            state <= RD_SHIFT;
          end
          RD_SHIFT: begin
            if (cnt == RD_BITS) begin
              state <= DONE;
            end else begin
              MISO <= sr_q[MEM_WIDTH-1];
              cnt  <= cnt + 1'b1;
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
